fifo_byte_packer: RTL and testbench
===================================

FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, FIFO word width in bits; multiple of 8, minimum 16; BYTES = WIDTH/8.
REQ-002 SHALL have port: clk_w_i  input  1  write-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: s_data_i  input  8  upstream byte.
REQ-005 SHALL have port: s_valid_i  input  1  upstream byte valid.
REQ-006 SHALL have port: s_last_i  input  1  byte is last of packet; qualified by s_valid_i.
REQ-007 SHALL have port: s_ready_o  output  1  packer accepts byte this cycle.
REQ-008 SHALL have port: fifo_full_i  input  1  full flag from the async FIFO write side.
REQ-009 SHALL have port: fifo_wdata_o  output  WIDTH  word to FIFO write data.
REQ-010 SHALL have port: fifo_wenable_o  output  1  FIFO write enable.
REQ-011 SHALL have port: busy_o  output  1  accumulator non-empty or hold register occupied.
REQ-012 SHALL have port: words_written_o  output  16  FIFO write count; present only with WORD_COUNT_EN.

Function
REQ-013 SHALL transfer a byte on a clk_w_i edge where s_valid_i && s_ready_o.
REQ-014 SHALL store the k-th accepted byte of a word (k = 0..BYTES-1) at bits [8k+7:8k] of the accumulator (little-endian).
REQ-015 SHALL keep a byte count acc_cnt (0..BYTES-1) and a hold register with flag hold_valid.
REQ-016 SHALL, when a transferred byte completes a word (acc_cnt == BYTES-1) or carries s_last_i, move the assembled word into the hold register on that edge, set hold_valid, clear the accumulator to zero, and reset acc_cnt to 0.
REQ-017 SHALL zero-fill unfilled upper bytes of a word closed early by s_last_i.
REQ-018 SHALL drive fifo_wdata_o from the hold register and fifo_wenable_o = hold_valid && !fifo_full_i (combinational).
REQ-019 SHALL clear hold_valid on an edge where fifo_wenable_o is 1, unless a new word loads the same edge, in which case hold_valid stays 1 with the new word.
REQ-020 SHALL drive s_ready_o = !hold_valid || !fifo_full_i.
REQ-021 SHALL give latency: word-closing byte at edge N -> fifo_wenable_o high in the cycle after edge N when fifo_full_i is 0.
REQ-022 SHALL hold fifo_wdata_o stable and keep hold_valid set for any number of cycles with fifo_full_i = 1; no word SHALL be dropped or duplicated.
REQ-023 SHALL drive busy_o = hold_valid || (acc_cnt != 0).
REQ-024 SHALL ignore s_data_i and s_last_i when s_valid_i is 0.

Reset
REQ-025 SHALL, while rst_i = 0, force accumulator, acc_cnt, hold register, hold_valid, and word counter to 0, giving fifo_wenable_o = 0, fifo_wdata_o = 0, busy_o = 0, s_ready_o = 1.
REQ-026 SHALL discard any partial or held word on reset assertion mid-operation, and resume with an empty accumulator on the first edge after release.

Configuration
REQ-027 SHALL implement words_written_o only when macro FIFO_BYTE_PACKER_WORD_COUNT_EN is defined: 16-bit counter, +1 per cycle with fifo_wenable_o = 1, wraps 0xFFFF -> 0x0000.
REQ-028 SHALL, without FIFO_BYTE_PACKER_WORD_COUNT_EN, omit the port and counter; all other behaviour identical.

Verification
REQ-029 SHALL cover: WIDTH=32, bytes 0x11,0x22,0x33,0x44 back-to-back, fifo_full_i=0 -> one write of 0x44332211 in cycle after 4th byte.
REQ-030 SHALL cover: bytes 0xAA,0xBB with s_last_i on 0xBB -> one write of 0x0000BBAA; busy_o low after write.
REQ-031 SHALL cover: fifo_full_i=1 held 10 cycles while word 0xDEADBEEF held, upstream streaming -> s_ready_o=0, fifo_wdata_o stable, single write after full drops.
REQ-032 SHALL cover: continuous 12-byte stream 0x00..0x0B, full never asserted -> writes 0x03020100, 0x07060504, 0x0B0A0908 in order, no stall.
REQ-033 SHALL cover: rst_i pulsed low after 2 of 4 bytes -> no write; next 4 bytes 0x01..0x04 produce 0x04030201.
REQ-034 SHALL cover: with FIFO_BYTE_PACKER_WORD_COUNT_EN, counter preloaded via 65537 writes -> words_written_o = 0x0001.

Source files
------------

// File: rtl/fifo_byte_packer.sv
// fifo_byte_packer: packs upstream bytes little-endian into WIDTH-bit words for an async FIFO write side.
// Defining FIFO_BYTE_PACKER_WORD_COUNT_EN adds the 16-bit words_written_o write counter.
module fifo_byte_packer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_w_i,
  input  logic             rst_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  input  logic             fifo_full_i,
  output logic [WIDTH-1:0] fifo_wdata_o,
  output logic             fifo_wenable_o,
  output logic             busy_o
`ifdef FIFO_BYTE_PACKER_WORD_COUNT_EN
  ,
  output logic [15:0]      words_written_o
`endif
);
  localparam int BYTES = WIDTH / 8;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  logic [WIDTH-1:0] acc, hold, merged;
  logic [CW-1:0] acc_cnt;
  logic hold_valid, accept, close;
  assign s_ready_o = !hold_valid || !fifo_full_i;
  assign fifo_wenable_o = hold_valid && !fifo_full_i;
  assign fifo_wdata_o = hold;
  assign busy_o = hold_valid || (acc_cnt != '0);
  assign accept = s_valid_i && s_ready_o;
  assign close = accept && (acc_cnt == CW'(BYTES - 1) || s_last_i);
  assign merged = acc | (WIDTH'(s_data_i) << {acc_cnt, 3'b000});
  always_ff @(posedge clk_w_i or negedge rst_i) begin
    if (!rst_i) begin
      acc <= '0;
      acc_cnt <= '0;
      hold <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (accept) begin
        acc <= close ? '0 : merged;
        acc_cnt <= close ? '0 : acc_cnt + 1'b1;
      end
      if (close) begin
        hold <= merged;
        hold_valid <= 1'b1;
      end else if (fifo_wenable_o) begin
        hold_valid <= 1'b0;
      end
    end
  end
`ifdef FIFO_BYTE_PACKER_WORD_COUNT_EN
  always_ff @(posedge clk_w_i or negedge rst_i) begin
    if (!rst_i) words_written_o <= '0;
    else if (fifo_wenable_o) words_written_o <= words_written_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fifo_byte_packer.sv
// tb_fifo_byte_packer: directed checks of byte packing, backpressure, reset and optional write counter.
module tb_fifo_byte_packer;
  logic clk_w_i = 1'b0;
  logic rst_i = 1'b0;
  logic [7:0] s_data_i = '0;
  logic s_valid_i = 1'b0;
  logic s_last_i = 1'b0;
  logic s_ready_o;
  logic fifo_full_i = 1'b0;
  logic [31:0] fifo_wdata_o;
  logic fifo_wenable_o;
  logic busy_o;
`ifdef FIFO_BYTE_PACKER_WORD_COUNT_EN
  logic [15:0] words_written_o;
`endif
  int passed = 0;
  int total = 0;
  logic [31:0] wq[$];
  fifo_byte_packer #(.WIDTH(32)) dut (
    .clk_w_i(clk_w_i),
    .rst_i(rst_i),
    .s_data_i(s_data_i),
    .s_valid_i(s_valid_i),
    .s_last_i(s_last_i),
    .s_ready_o(s_ready_o),
    .fifo_full_i(fifo_full_i),
    .fifo_wdata_o(fifo_wdata_o),
    .fifo_wenable_o(fifo_wenable_o),
    .busy_o(busy_o)
`ifdef FIFO_BYTE_PACKER_WORD_COUNT_EN
    ,
    .words_written_o(words_written_o)
`endif
  );
  always #5 clk_w_i = ~clk_w_i;
  always @(negedge clk_w_i) if (rst_i && fifo_wenable_o) wq.push_back(fifo_wdata_o);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk_w_i);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic last);
    s_valid_i = 1'b1;
    s_data_i = d;
    s_last_i = last;
    tick();
    s_valid_i = 1'b0;
    s_last_i = 1'b0;
  endtask
  initial begin
    #12;
    check("rst_wen", fifo_wenable_o, 0);
    check("rst_wdata", fifo_wdata_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", s_ready_o, 1);
    rst_i = 1'b1;
    tick();
    wq.delete();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    check("t1_wen", fifo_wenable_o, 1);
    check("t1_wdata", fifo_wdata_o, 32'h44332211);
    tick();
    check("t1_wen_off", fifo_wenable_o, 0);
    check("t1_busy", busy_o, 0);
    check("t1_n", wq.size(), 1);
    check("t1_w", wq[0], 32'h44332211);
    wq.delete();
    send(8'hAA, 0);
    check("t2_busy_partial", busy_o, 1);
    send(8'hBB, 1);
    check("t2_wdata", fifo_wdata_o, 32'h0000BBAA);
    check("t2_wen", fifo_wenable_o, 1);
    tick();
    check("t2_busy", busy_o, 0);
    check("t2_n", wq.size(), 1);
    check("t2_w", wq[0], 32'h0000BBAA);
    wq.delete();
    fifo_full_i = 1'b1;
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    s_valid_i = 1'b1;
    s_data_i = 8'h55;
    for (int i = 0; i < 10; i++) begin
      check("t3_ready", s_ready_o, 0);
      check("t3_wdata", fifo_wdata_o, 32'hDEADBEEF);
      check("t3_wen", fifo_wenable_o, 0);
      tick();
    end
    s_valid_i = 1'b0;
    check("t3_busy", busy_o, 1);
    fifo_full_i = 1'b0;
    #1;
    check("t3_wen_rel", fifo_wenable_o, 1);
    tick();
    tick();
    check("t3_busy_end", busy_o, 0);
    check("t3_n", wq.size(), 1);
    check("t3_w", wq[0], 32'hDEADBEEF);
    wq.delete();
    for (int i = 0; i < 12; i++) begin
      s_valid_i = 1'b1;
      s_data_i = 8'(i);
      check("t4_ready", s_ready_o, 1);
      tick();
    end
    s_valid_i = 1'b0;
    tick();
    check("t4_n", wq.size(), 3);
    check("t4_w0", wq[0], 32'h03020100);
    check("t4_w1", wq[1], 32'h07060504);
    check("t4_w2", wq[2], 32'h0B0A0908);
    wq.delete();
    send(8'hC1, 0); send(8'hC2, 0);
    #2 rst_i = 1'b0;
    #1;
    check("t5_busy_rst", busy_o, 0);
    check("t5_wen_rst", fifo_wenable_o, 0);
    #2 rst_i = 1'b1;
    tick();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    tick();
    check("t5_n", wq.size(), 1);
    check("t5_w", wq[0], 32'h04030201);
`ifdef FIFO_BYTE_PACKER_WORD_COUNT_EN
    #2 rst_i = 1'b0;
    #2 rst_i = 1'b1;
    check("t6_cnt_rst", words_written_o, 0);
    tick();
    for (int i = 0; i < 65537; i++) send(8'(i), 1);
    tick();
    check("t6_cnt_wrap", words_written_o, 16'h0001);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
